// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register bank: status byte layout and the
// addresses of the special registers that follow the RW block.
package spi_reg_pkg;

  localparam int ST_IRQ     = 7;
  localparam int ST_ERR     = 6;
  localparam int ST_CNT_LSB = 0;
  localparam int CNT_W      = 4;

  // The read-only input register and the flag register sit directly after the RW block.
  function automatic int a_in(input int num_rw);
    return num_rw;
  endfunction

  function automatic int a_flag(input int num_rw);
    return num_rw + 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// W-bit two-flop synchronizer with a rising-edge pulse against the previous
// synchronized value; every flop holds while ena is low.
module sync_edge_detect #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         ena,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else if (ena) begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// Register file behind the SPI register slave: RW config registers, a
// synchronized input register, W1C event flags, status byte and interrupt.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8,
  parameter int NUM_RW = 6
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    ena,
  input  logic [ADDR_W-1:0]       reg_addr,
  input  logic [REG_W-1:0]        reg_wdata,
  input  logic                    reg_wdata_dv,
  output logic [REG_W-1:0]        reg_rdata,
  output logic [7:0]              status,
  input  logic [REG_W-1:0]        ev_in,
  output logic [NUM_RW*REG_W-1:0] cfg_o,
  output logic                    irq
);

  localparam logic [ADDR_W-1:0] L_NUM_RW = ADDR_W'(NUM_RW);
  localparam logic [ADDR_W-1:0] L_A_IN   = ADDR_W'(a_in(NUM_RW));
  localparam logic [ADDR_W-1:0] L_A_FLAG = ADDR_W'(a_flag(NUM_RW));

  logic [REG_W-1:0] r_cfg [NUM_RW];
  logic [REG_W-1:0] r_flags;
  logic [REG_W-1:0] r_rdata;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             r_err;
  logic             r_irq;

  logic [REG_W-1:0] w_ev_sync;
  logic [REG_W-1:0] w_ev_rise;
  logic [REG_W-1:0] w_rd_mux;
  logic [REG_W-1:0] w_clr;
  logic             w_is_rw;
  logic             w_is_flag;
  logic [7:0]       w_status;

  sync_edge_detect #(.W(REG_W)) u_sync (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .i_async (ev_in),
    .o_sync  (w_ev_sync),
    .o_rise  (w_ev_rise)
  );

  assign w_is_rw   = (reg_addr < L_NUM_RW);
  assign w_is_flag = (reg_addr == L_A_FLAG);
  assign w_clr     = (reg_wdata_dv && w_is_flag) ? reg_wdata : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_rd_mux = '0;
    if (w_is_rw)                    w_rd_mux = r_cfg[reg_addr];
    else if (reg_addr == L_A_IN)    w_rd_mux = w_ev_sync;
    else if (w_is_flag)             w_rd_mux = r_flags;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      // NOTE: the register array is reset element by element; its contents are visible on cfg_o.
      for (int k = 0; k < NUM_RW; k++) r_cfg[k] <= '0;
      r_flags  <= '0;
      r_rdata  <= '0;
      r_wr_cnt <= '0;
      r_err    <= 1'b0;
      r_irq    <= 1'b0;
    end else if (ena) begin
      if (reg_wdata_dv) begin
        if (w_is_rw) begin
          r_cfg[reg_addr] <= reg_wdata;
          r_wr_cnt        <= r_wr_cnt + 1'b1;
        end else if (w_is_flag) begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
          r_err    <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
      // Set is applied after the clear so a same-cycle edge keeps its flag.
      r_flags <= (r_flags & ~w_clr) | w_ev_rise;
      r_irq   <= |(r_flags & r_cfg[NUM_RW-1]);
      r_rdata <= w_rd_mux;
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_cfg
    assign cfg_o[k*REG_W +: REG_W] = r_cfg[k];
  end

  always_comb begin
    w_status                      = '0;
    w_status[ST_IRQ]              = r_irq;
    w_status[ST_ERR]              = r_err;
    w_status[ST_CNT_LSB +: CNT_W] = r_wr_cnt;
  end

  assign status    = w_status;
  assign reg_rdata = r_rdata;
  assign irq       = r_irq;

endmodule
